// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op codes, FSM states, defaults.
package shift_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SHW   = 5;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROR  = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // True for op codes that actually move bits; pass and unused codes are not.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift/rotate step selected by op; anything else passes through.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // One-bit step for the selected operation
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shifter: latches operand/amount on start, shifts one bit per clock,
// then pulses done with the final result held until the next accepted start.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nx;
  logic [SHW-1:0]   count;
  logic [2:0]       op;
  logic [WIDTH-1:0] stepped;
  logic             load;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op),
    .din  (result),
    .dout (stepped)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state, load decision and Moore handshake outputs
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    busy     = (state == ST_SHIFT);
    done     = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (shamt == '0 || !is_shift_op(shift_op)) ? ST_DONE : ST_SHIFT;
        end else if (state == ST_DONE) begin
          state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count == SHW'(1)) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand, op and remaining-count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      count  <= '0;
      op     <= OP_PASS;
    end else if (load) begin
      result <= data_in;
      count  <= shamt;
      op     <= shift_op;
    end else if (state == ST_SHIFT) begin
      result <= stepped;
      count  <= count - SHW'(1);
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  shift_op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;

  shift_unit_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .shift_op (shift_op),
    .data_in  (data_in),
    .shamt    (shamt),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d, input int n);
    case (op)
      3'd1:    return d << n;
      3'd2:    return d >> n;
      3'd3:    return 32'($signed(d) >>> n);
      3'd4:    return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int n);
    return (op >= 3'd1 && op <= 3'd4 && n != 0) ? n : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done; returns edges waited and busy cycles observed.
  task automatic wait_done(input string tag, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done === 1'b1) done_pulses++;
  endtask

  // Issues one op, scrambles inputs after acceptance, checks result/latency/pulse.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d, input int n);
    int cyc, bcnt;
    logic [31:0] exp;
    exp = ref_shift(op, d, n);
    @(negedge clk);
    start = 1'b1; shift_op = op; data_in = d; shamt = 5'(n);
    @(negedge clk);
    start = 1'b0; shift_op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
    wait_done(tag, cyc, bcnt);
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(cyc), 32'(ref_lat(op, n)));
    check({tag, "_busycyc"}, 32'(bcnt), 32'(ref_lat(op, n)));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int cyc, bcnt;
    logic [2:0]  rop;
    logic [31:0] rd;
    int          rn;

    reset_n = 1'b0; start = 1'b0; shift_op = 3'd0; data_in = '0; shamt = '0;
    #1;
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: abort mid-shift
    @(negedge clk);
    start = 1'b1; shift_op = 3'd1; data_in = 32'h0000_0003; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);

    // 2..4, 6: directed corners
    done_pulses = 0;
    run_op("sll4",    3'd1, 32'h0000_0001, 4);
    run_op("sra31",   3'd3, 32'h8000_0000, 31);
    run_op("srl31",   3'd2, 32'h8000_0000, 31);
    run_op("ror1",    3'd4, 32'h0000_0001, 1);
    run_op("ror31",   3'd4, 32'h0000_0001, 31);
    run_op("ror0",    3'd4, 32'h1234_5678, 0);
    run_op("inv7",    3'd7, 32'hDEAD_BEEF, 7);
    run_op("pass5",   3'd0, 32'hCAFE_F00D, 5);
    check("directed_pulses", 32'(done_pulses), 32'd8);

    // 5: start held during SHIFT ignored; start in DONE accepted back-to-back
    done_pulses = 0;
    @(negedge clk);
    start = 1'b1; shift_op = 3'd1; data_in = 32'h0000_0003; shamt = 5'd5;
    @(negedge clk);
    shift_op = 3'd2; data_in = 32'hFFFF_0000; shamt = 5'd2;
    wait_done("b2b_first", cyc, bcnt);
    check("b2b_first_result", result, 32'h0000_0060);
    check("b2b_first_latency", 32'(cyc), 32'd5);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", cyc, bcnt);
    check("b2b_second_result", result, 32'h3FFF_C000);
    check("b2b_second_latency", 32'(cyc), 32'd2);
    check("b2b_pulses", 32'(done_pulses), 32'd2);
    @(negedge clk);

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = $urandom;
      rn  = $urandom_range(0, 31);
      run_op($sformatf("rnd%0d_op%0d_n%0d", i, rop, rn), rop, rd, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
